score_digits_display: RTL

Consumer side of the two-digit BCD score. It takes the units and tens digits from the score counter and renders them as a scaled bitmap glyph pair in the VGA pixel stream. Digits are latched once per frame so the picture never tears. A score change triggers a timed colour flash. Output feeds the object-priority mux like any other drawing object.

---
 rtl/score_display_pkg.sv | 25 ++
 rtl/score_digits_display_digit_font_rom.sv | 49 ++++
 rtl/score_digits_display.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared font geometry, glyph types and digit-to-glyph mapping for the
// score digit renderer.
`timescale 1ns/1ps
package score_display_pkg;

   localparam int FONT_W     = 8;
   localparam int FONT_H     = 16;
   localparam int GLYPH_DASH = 10;
   localparam int NUM_GLYPHS = 11;

   typedef logic [3:0] glyph_idx_t;
   typedef logic [7:0] font_row_t;

   // Non-decimal values (e.g. tens underflow below 00) render as a dash.
   function automatic glyph_idx_t digit_to_glyph(input logic [3:0] value);
      glyph_idx_t glyph;
      if (value >= 4'(GLYPH_DASH)) begin
         glyph = 4'(GLYPH_DASH);
      end else begin
         glyph = value;
      end
      return glyph;
   endfunction

endpackage

// File: rtl/score_digits_display_digit_font_rom.sv
// 11-glyph 8x16 seven-segment style font with a registered row read.
// Row 0 sits in the top byte of each glyph word; bit 7 is the leftmost column.
`timescale 1ns/1ps
module digit_font_rom
   import score_display_pkg::*;
(
   input  logic       clk,
   input  logic       resetN,
   input  glyph_idx_t glyph,
   input  logic [3:0] row,
   output font_row_t  row_bits
);

   logic [127:0] glyph_bits;
   logic [6:0]   bit_base;
   font_row_t    row_bits_d;
   font_row_t    row_bits_q;

   // Glyph table lookup and row slice.
   always_comb begin
      case (glyph)
         4'd0:    glyph_bits = 128'hFF81818181818181_00818181818181FF;
         4'd1:    glyph_bits = 128'h0001010101010101_0001010101010100;
         4'd2:    glyph_bits = 128'hFF01010101010101_FF808080808080FF;
         4'd3:    glyph_bits = 128'hFF01010101010101_FF010101010101FF;
         4'd4:    glyph_bits = 128'h0081818181818181_FF01010101010100;
         4'd5:    glyph_bits = 128'hFF80808080808080_FF010101010101FF;
         4'd6:    glyph_bits = 128'hFF80808080808080_FF818181818181FF;
         4'd7:    glyph_bits = 128'hFF01010101010101_0001010101010100;
         4'd8:    glyph_bits = 128'hFF81818181818181_FF818181818181FF;
         4'd9:    glyph_bits = 128'hFF81818181818181_FF010101010101FF;
         default: glyph_bits = 128'h0000000000000000_FF00000000000000;
      endcase
      bit_base   = 7'd120 - {row, 3'b000};
      row_bits_d = glyph_bits[bit_base +: 8];
   end

   // Synchronous read register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         row_bits_q <= 8'h00;
      end else begin
         row_bits_q <= row_bits_d;
      end
   end

   assign row_bits = row_bits_q;

endmodule

// File: rtl/score_digits_display.sv
// Two-digit score renderer: frame-latched digits, change flash and a
// two-stage pixel pipeline feeding the object-priority mux.
`timescale 1ns/1ps
module score_digits_display
   import score_display_pkg::*;
#(
   parameter int         TOP_LEFT_X    = 16,
   parameter int         TOP_LEFT_Y    = 16,
   parameter int         SCALE_LOG2    = 1,
   parameter int         DIGIT_GAP     = 4,
   parameter logic [7:0] COLOR         = 8'hFF,
   parameter logic [7:0] FLASH_COLOR   = 8'hE0,
   parameter int         FLASH_FRAMES  = 30,
   parameter bit         BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic [3:0]  dig1,
   input  logic [3:0]  dig2,
   output logic        drawingRequest,
   output logic [7:0]  RGBout
);

   localparam int         CELL_W     = FONT_W << SCALE_LOG2;
   localparam int         CELL_H     = FONT_H << SCALE_LOG2;
   localparam logic [11:0] TENS_X0   = 12'(TOP_LEFT_X);
   localparam logic [11:0] TENS_X1   = 12'(TOP_LEFT_X + CELL_W);
   localparam logic [11:0] UNITS_X0  = 12'(TOP_LEFT_X + CELL_W + DIGIT_GAP);
   localparam logic [11:0] UNITS_X1  = 12'(TOP_LEFT_X + 2 * CELL_W + DIGIT_GAP);
   localparam logic [11:0] CELL_Y0   = 12'(TOP_LEFT_Y);
   localparam logic [11:0] CELL_Y1   = 12'(TOP_LEFT_Y + CELL_H);
   localparam logic [7:0]  FLASH_LOAD = 8'(FLASH_FRAMES);

   logic [11:0] px;
   logic [11:0] py;
   logic [11:0] x_off;
   logic [11:0] y_off;
   logic        in_tens;
   logic        in_units;
   logic        in_y;
   font_row_t   rom_row;

   logic [3:0]  shown_dig1_d, shown_dig1_q;
   logic [3:0]  shown_dig2_d, shown_dig2_q;
   logic [7:0]  flash_cnt_d,  flash_cnt_q;
   logic        hit1_d,   hit1_q;
   glyph_idx_t  glyph1_d, glyph1_q;
   logic [3:0]  row1_d,   row1_q;
   logic [2:0]  col1_d,   col1_q;
   logic        blank1_d, blank1_q;
   logic        hit2_d,   hit2_q;
   logic        blank2_d, blank2_q;
   logic [2:0]  col2_d,   col2_q;
   logic [7:0]  color_d,  color_q;

   // Frame latch, flash counter, geometry stage and colour select.
   always_comb begin
      shown_dig1_d = shown_dig1_q;
      shown_dig2_d = shown_dig2_q;
      flash_cnt_d  = flash_cnt_q;
      if (startOfFrame) begin
         shown_dig1_d = dig1;
         shown_dig2_d = dig2;
         if ({dig2, dig1} != {shown_dig2_q, shown_dig1_q}) begin
            flash_cnt_d = FLASH_LOAD;
         end else if (flash_cnt_q != 8'd0) begin
            flash_cnt_d = flash_cnt_q - 8'd1;
         end else begin
            flash_cnt_d = flash_cnt_q;
         end
      end else begin
         flash_cnt_d = flash_cnt_q;
      end

      px       = {1'b0, pixelX};
      py       = {1'b0, pixelY};
      in_tens  = (px >= TENS_X0) && (px < TENS_X1);
      in_units = (px >= UNITS_X0) && (px < UNITS_X1);
      in_y     = (py >= CELL_Y0) && (py < CELL_Y1);
      if (in_units) begin
         x_off = px - UNITS_X0;
      end else begin
         x_off = px - TENS_X0;
      end
      y_off = py - CELL_Y0;

      hit1_d   = in_y && (in_tens || in_units);
      glyph1_d = in_units ? digit_to_glyph(shown_dig1_q) : digit_to_glyph(shown_dig2_q);
      row1_d   = 4'(y_off >> SCALE_LOG2);
      col1_d   = 3'(x_off >> SCALE_LOG2);
      blank1_d = BLANK_LEADING && in_tens && (shown_dig2_q == 4'd0);

      // The ROM register runs in parallel with these, forming stage 2.
      hit2_d   = hit1_q;
      blank2_d = blank1_q;
      col2_d   = col1_q;
      if ((flash_cnt_q != 8'd0) && flash_cnt_q[2]) begin
         color_d = FLASH_COLOR;
      end else begin
         color_d = COLOR;
      end
   end

   // State and pipeline registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shown_dig1_q <= 4'd0;
         shown_dig2_q <= 4'd0;
         flash_cnt_q  <= 8'd0;
         hit1_q       <= 1'b0;
         glyph1_q     <= 4'd0;
         row1_q       <= 4'd0;
         col1_q       <= 3'd0;
         blank1_q     <= 1'b0;
         hit2_q       <= 1'b0;
         blank2_q     <= 1'b0;
         col2_q       <= 3'd0;
         color_q      <= 8'h00;
      end else begin
         shown_dig1_q <= shown_dig1_d;
         shown_dig2_q <= shown_dig2_d;
         flash_cnt_q  <= flash_cnt_d;
         hit1_q       <= hit1_d;
         glyph1_q     <= glyph1_d;
         row1_q       <= row1_d;
         col1_q       <= col1_d;
         blank1_q     <= blank1_d;
         hit2_q       <= hit2_d;
         blank2_q     <= blank2_d;
         col2_q       <= col2_d;
         color_q      <= color_d;
      end
   end

   digit_font_rom u_font (
      .clk      (clk),
      .resetN   (resetN),
      .glyph    (glyph1_q),
      .row      (row1_q),
      .row_bits (rom_row)
   );

   assign drawingRequest = hit2_q & ~blank2_q & rom_row[3'd7 - col2_q];
   assign RGBout         = color_q;

endmodule
